seq_arith_unit: RTL and testbench
=================================

// Module: seq_arith_unit
// PURPOSE
//  Parametrised, handshaked successor to the combinational adder/sub/mul unit.
//  Accepts one operation at a time via valid/ready, computes ADD/SUB in one cycle
//  and MUL iteratively (shift-add, one bit per cycle), and holds the result until consumed.
//  Sits between an operand source (testbench or sequencer) and a result sink.
// PARAMETERS
//  WIDTH   8   operand width in bits; legal range >= 2; result is 2*WIDTH bits
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        operand/op presented
//  in_ready   out  1        unit can accept an operation
//  op         in   2        00 ADD, 01 SUB, 10 MUL, 11 reserved
//  a, b       in   WIDTH    unsigned operands
//  out_valid  out  1        result valid
//  out_ready  in   1        sink accepts result
//  result     out  2*WIDTH  unsigned result, zero-extended for ADD/SUB
//  ovf        out  1        ADD carry-out / SUB borrow; 0 for MUL and reserved
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=1 after release; out_valid=0, result=0, ovf=0, counter=0.
//  - FSM: IDLE -> (accept, op!=MUL) -> DONE; IDLE -> (accept, op=MUL) -> CALC;
//    CALC -> (WIDTH iterations complete) -> DONE; DONE -> (out_valid&&out_ready) -> IDLE.
//  - Accept = in_valid && in_ready; in_ready = (state==IDLE). a, b, op are registered on accept.
//  - Latency: ADD/SUB/reserved: out_valid 1 cycle after accept. MUL: WIDTH+1 cycles after accept.
//  - Throughput: no bypass; next accept no earlier than the cycle after the output handshake.
//  - ADD: result = {WIDTH'b0, (a+b) mod 2^WIDTH}; ovf = carry-out.
//  - SUB: result = {WIDTH'b0, (a-b) mod 2^WIDTH}; ovf = 1 iff a < b.
//  - MUL: full 2*WIDTH product; one multiplier bit per CALC cycle (LSB first); ovf=0.
//  - Reserved op (11): result=0, ovf=0, 1-cycle latency; not an error, no hang.
//  - DONE: result/ovf held stable while out_valid=1 and out_ready=0 (any number of cycles).
//  - in_valid asserted while busy: ignored, operands not sampled; source must hold.
//  - rst_n asserted mid-operation: immediate abort, all outputs to reset values, partial product lost.
// CONFIGURATION
//  ARITH_SAT_EN defined: ADD with carry -> low WIDTH bits = all ones (2^WIDTH-1);
//    SUB with borrow -> result=0; ovf still reports the saturation event. MUL unaffected.
//  ARITH_SAT_EN undefined: ADD/SUB wrap modulo 2^WIDTH as above.
// STRUCTURE
//  - Package arith_pkg: op encoding localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10,
//    OP_RSV=2'b11; FSM state encoding ST_IDLE/ST_CALC/ST_DONE.
//  - Sub-module shift_add_mul: iterative multiplier datapath (accumulator, shifted
//    multiplicand, multiplier shift reg, $clog2(WIDTH+1)-bit counter, start/done).
//  - Top: FSM, operand registers, ADD/SUB logic, output registers, ARITH_SAT_EN muxing.
// TESTING (WIDTH=8)
//  1. ADD a=10 b=5 -> out_valid 1 cycle after accept, result=15, ovf=0.
//  2. ADD a=200 b=100 -> result=44, ovf=1; with ARITH_SAT_EN result=255, ovf=1.
//  3. SUB a=5 b=10 -> result=251, ovf=1; with ARITH_SAT_EN result=0, ovf=1.
//  4. MUL a=255 b=255 -> in_ready=0 for 9 cycles, then result=65025, ovf=0, out_valid=1.
//  5. ADD 3+4 with out_ready=0 for 3 cycles -> result=7 stable, in_ready=0; out_ready=1 -> IDLE next cycle.
//  6. rst_n low during 4th CALC cycle of MUL 12*13 -> out_valid=0, result=0 at once; after release
//     in_ready=1 and a fresh MUL 12*13 -> 156.

Source files
------------

// File: rtl/arith_pkg.sv
// ============================================================================
// Module   : arith_pkg
// Purpose  : Opcode and FSM state encodings shared by the sequential arithmetic unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arith_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage : arith_pkg

`default_nettype wire

// File: rtl/seq_arith_unit_if.sv
// ============================================================================
// Module   : seq_arith_unit_if
// Purpose  : Operand/result valid-ready bus between source, unit and sink.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_arith_unit_if #(
    parameter int WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [1:0]             op;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     result;
    logic                   ovf;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, ovf
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, ovf
    );
endinterface : seq_arith_unit_if

`default_nettype wire

// File: rtl/shift_add_mul.sv
// ============================================================================
// Module   : shift_add_mul
// Purpose  : Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_add_mul #(
    parameter int WIDTH = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 i_start,
    input  wire logic [WIDTH-1:0]     i_multiplicand,
    input  wire logic [WIDTH-1:0]     i_multiplier,
    output logic                      o_last,
    output logic [2*WIDTH-1:0]        o_product_nxt
);

    localparam int              c_CW   = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [c_CW-1:0]    cnt_q,    cnt_d;
    logic               busy_q,   busy_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (i_start) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, i_multiplicand};
            mplier_d = i_multiplier;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            // LSB-first: add the shifted multiplicand when the current bit is set
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + c_ONE;
            busy_d   = (cnt_q != c_LAST);
        end
    end

    // The final product is handed over combinationally so the caller can
    // register it on the same edge that retires the last iteration.
    assign o_last        = busy_q && (cnt_q == c_LAST);
    assign o_product_nxt = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule : shift_add_mul

`default_nettype wire

// File: rtl/seq_arith_unit.sv
// ============================================================================
// Module   : seq_arith_unit
// Purpose  : Handshaked ADD/SUB (single cycle) and iterative MUL unit with held result.
//            Optional macro ARITH_SAT_EN saturates ADD/SUB instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_arith_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    seq_arith_unit_if.slave  bus
);

    state_e               state_q,     state_d;
    logic                 in_ready_q,  in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0]   result_q,    result_d;
    logic                 ovf_q,       ovf_d;

    logic                 w_accept;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic                 w_carry;
    logic                 w_borrow;
    logic [WIDTH-1:0]     w_add_lo;
    logic [WIDTH-1:0]     w_sub_lo;
    logic                 w_mul_start;
    logic                 w_mul_last;
    logic [2*WIDTH-1:0]   w_mul_product;

    assign w_accept = bus.in_valid && in_ready_q;
    assign w_sum    = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_diff   = {1'b0, bus.a} - {1'b0, bus.b};
    assign w_carry  = w_sum[WIDTH];
    assign w_borrow = w_diff[WIDTH];

`ifdef ARITH_SAT_EN
    assign w_add_lo = w_carry  ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
    assign w_sub_lo = w_borrow ? {WIDTH{1'b0}} : w_diff[WIDTH-1:0];
`else
    assign w_add_lo = w_sum[WIDTH-1:0];
    assign w_sub_lo = w_diff[WIDTH-1:0];
`endif

    // Operands are captured on accept: ADD/SUB straight into the result
    // register, MUL into the multiplier's own working registers.
    shift_add_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (w_mul_start),
        .i_multiplicand (bus.a),
        .i_multiplier   (bus.b),
        .o_last         (w_mul_last),
        .o_product_nxt  (w_mul_product)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        w_mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    case (bus.op)
                        OP_ADD: begin
                            result_d = {{WIDTH{1'b0}}, w_add_lo};
                            ovf_d    = w_carry;
                        end
                        OP_SUB: begin
                            result_d = {{WIDTH{1'b0}}, w_sub_lo};
                            ovf_d    = w_borrow;
                        end
                        OP_MUL: begin
                            w_mul_start = 1'b1;
                            ovf_d       = 1'b0;
                        end
                        OP_RSV: begin
                            result_d = '0;
                            ovf_d    = 1'b0;
                        end
                    endcase
                    if (bus.op == OP_MUL) begin
                        state_d = ST_CALC;
                    end else begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                if (w_mul_last) begin
                    result_d    = w_mul_product;
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.ovf       = ovf_q;

endmodule : seq_arith_unit

`default_nettype wire

// File: tb/tb_seq_arith_unit.sv
// ============================================================================
// Module   : tb_seq_arith_unit
// Purpose  : Directed-vector bench for seq_arith_unit (WIDTH=8) with a queued scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_arith_unit;
    import arith_pkg::*;

    localparam int WIDTH = 8;

`ifdef ARITH_SAT_EN
    localparam logic [15:0] c_ADD_200_100 = 16'd255;
    localparam logic [15:0] c_SUB_5_10    = 16'd0;
    localparam logic [15:0] c_ADD_255_1   = 16'd255;
`else
    localparam logic [15:0] c_ADD_200_100 = 16'd44;
    localparam logic [15:0] c_SUB_5_10    = 16'd251;
    localparam logic [15:0] c_ADD_255_1   = 16'd0;
`endif

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        ovf;
        int          lat;
        int          hold;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] res;
        logic        ovf;
    } sb_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    sb_t  sb_q[$];
    sb_t  mon_e;
    vec_t vecs[$];

    seq_arith_unit_if #(.WIDTH(WIDTH)) bus ();

    seq_arith_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard consumer: pops one expectation per output handshake
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_output", 32'(sb_q.size()), 32'd1);
            end else begin
                mon_e = sb_q.pop_front();
                chk({mon_e.name, "_result"}, 32'(bus.result), 32'(mon_e.res));
                chk({mon_e.name, "_ovf"},    32'(bus.ovf),    32'(mon_e.ovf));
            end
        end
    end

    task automatic run_op(input vec_t v);
        int  n;
        int  lat;
        sb_t e;
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.op        = v.op;
        bus.a         = v.a;
        bus.b         = v.b;
        bus.out_ready = (v.hold == 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 50);
        if (!bus.in_ready) begin
            chk({v.name, "_accept"}, 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        e.name = v.name;
        e.res  = v.res;
        e.ovf  = v.ovf;
        sb_q.push_back(e);
        @(posedge clk); #1;
        // Scramble the bus so late sampling of operands would be visible
        bus.in_valid = 1'b0;
        bus.op       = ~v.op;
        bus.a        = ~v.a;
        bus.b        = ~v.b;
        lat = 1;
        @(negedge clk);
        chk({v.name, "_busy"}, 32'(bus.in_ready), 32'd0);
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({v.name, "_lat"}, 32'(lat), 32'(v.lat));
        if (v.hold > 0) begin
            for (int i = 0; i < v.hold; i++) begin
                chk({v.name, "_hold_result"}, 32'(bus.result), 32'(v.res));
                chk({v.name, "_hold_inrdy"},  32'(bus.in_ready), 32'd0);
                @(negedge clk);
            end
            chk({v.name, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk({v.name, "_idle_inrdy"}, 32'(bus.in_ready), 32'd1);
        chk({v.name, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = OP_ADD;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;

        vecs.push_back('{"add_10_5",    OP_ADD, 8'd10,  8'd5,   16'd15,        1'b0, 1, 0});
        vecs.push_back('{"add_200_100", OP_ADD, 8'd200, 8'd100, c_ADD_200_100, 1'b1, 1, 0});
        vecs.push_back('{"sub_5_10",    OP_SUB, 8'd5,   8'd10,  c_SUB_5_10,    1'b1, 1, 0});
        vecs.push_back('{"mul_255_255", OP_MUL, 8'd255, 8'd255, 16'd65025,     1'b0, 9, 0});
        vecs.push_back('{"add_3_4_hold",OP_ADD, 8'd3,   8'd4,   16'd7,         1'b0, 1, 3});
        vecs.push_back('{"sub_10_5",    OP_SUB, 8'd10,  8'd5,   16'd5,         1'b0, 1, 0});
        vecs.push_back('{"rsv_7_9",     OP_RSV, 8'd7,   8'd9,   16'd0,         1'b0, 1, 0});
        vecs.push_back('{"add_255_1",   OP_ADD, 8'd255, 8'd1,   c_ADD_255_1,   1'b1, 1, 0});
        vecs.push_back('{"sub_7_7",     OP_SUB, 8'd7,   8'd7,   16'd0,         1'b0, 1, 0});
        vecs.push_back('{"mul_0_200",   OP_MUL, 8'd0,   8'd200, 16'd0,         1'b0, 9, 0});
        vecs.push_back('{"mul_1_255",   OP_MUL, 8'd1,   8'd255, 16'd255,       1'b0, 9, 0});

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result",    32'(bus.result),    32'd0);
        chk("rst_ovf",       32'(bus.ovf),       32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);

        foreach (vecs[i]) run_op(vecs[i]);

        // Abort a MUL 12*13 in its fourth CALC cycle
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.op       = OP_MUL;
        bus.a        = 8'd12;
        bus.b        = 8'd13;
        @(negedge clk);
        chk("abort_accept", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_result",    32'(bus.result),    32'd0);
        chk("abort_ovf",       32'(bus.ovf),       32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready",  32'(bus.in_ready),  32'd1);
        run_op('{"mul_12_13", OP_MUL, 8'd12, 8'd13, 16'd156, 1'b0, 9, 0});

        repeat (5) @(negedge clk);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_seq_arith_unit

`default_nettype wire
